// File: rtl/dds_pwm_dac.sv
// -----------------------------------------------------------------------------
// dds_pwm_dac
//
// Converts the DDS sample stream into a registered PWM bit-stream for an
// external RC-filter DAC. A new sample (and carrier prescale) is latched only
// when the machine starts or at a carrier-period boundary, so a running pulse is
// never cut short by an input change in mid-period.
//
// Carrier: a DW-bit counter advanced once per carrier tick; a tick occurs every
// presc_q+1 clocks. One PWM period is 2^DW ticks. raw = (cnt < duty_q).
//
// Ports
//   clk           in   1    system clock
//   rstn          in   1    reset, synchronous, active-low
//   pwm_ena       in   1    run enable
//   din           in   DW   unsigned sample (from the DDS core)
//   prescale      in   8    carrier tick divider: tick every prescale+1 clocks
//   pwm_out       out  1    PWM high-side output, registered
//   pwm_outn      out  1    PWM complementary output, registered
//   period_start  out  1    1-clk pulse on the cycle a new sample is latched
//   duty_q        out  DW   sample currently being modulated
//
// Configuration
//   PWM_DEADTIME_EN  when defined, each output rises only after raw has held
//                    its level for DT consecutive clocks (dead band between the
//                    two outputs). When undefined, pwm_outn is the complement of
//                    pwm_out while running and DT is not used by the logic.
// -----------------------------------------------------------------------------
module dds_pwm_dac #(
   parameter int DW = 10,
   parameter int DT = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          pwm_ena,
   input  logic [DW-1:0] din,
   input  logic [7:0]    prescale,
   output logic          pwm_out,
   output logic          pwm_outn,
   output logic          period_start,
   output logic [DW-1:0] duty_q
);

   if (DT < 1 || DT > 15) begin : g_dt_range
      $error("dds_pwm_dac: DT must be in 1..15");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    pre_cnt_q, pre_cnt_d;
   logic [7:0]    presc_q, presc_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] duty_d;
   logic          pwm_out_d, pwm_outn_d, period_start_d;

   logic tick;
   logic boundary;
   logic raw;
   logic run_ok;

   // -------------------------------------------------------------------------
   // Carrier decode
   // -------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first, so no path can leave
   // a signal unassigned and infer a latch.
   always_comb begin
      run_ok   = (state_q == ST_RUN) && pwm_ena;
      tick     = (pre_cnt_q == presc_q);
      boundary = tick && (cnt_q == {DW{1'b1}});
      raw      = (cnt_q < duty_q);
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath
   // -------------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      pre_cnt_d      = pre_cnt_q;
      cnt_d          = cnt_q;
      duty_d         = duty_q;
      presc_d        = presc_q;
      period_start_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            pre_cnt_d = '0;
            cnt_d     = '0;
            if (pwm_ena) state_d = ST_START;
         end

         ST_START: begin
            pre_cnt_d = '0;
            cnt_d     = '0;
            if (!pwm_ena) begin
               // A drop on the start cycle wins: no latch, no strobe.
               state_d = ST_IDLE;
            end else begin
               duty_d         = din;
               presc_d        = prescale;
               period_start_d = 1'b1;
               state_d        = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!pwm_ena) begin
               state_d   = ST_IDLE;
               pre_cnt_d = '0;
               cnt_d     = '0;
            end else begin
               if (tick) begin
                  pre_cnt_d = '0;
                  cnt_d     = cnt_q + 1'b1;   // natural DW-bit wrap
               end else begin
                  pre_cnt_d = pre_cnt_q + 8'd1;
               end
               // Boundary: last tick of the period loads the next sample.
               if (boundary) begin
                  duty_d         = din;
                  presc_d        = prescale;
                  period_start_d = 1'b1;
               end
            end
         end

         default: begin
            state_d   = ST_IDLE;
            pre_cnt_d = '0;
            cnt_d     = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output shaping
   // -------------------------------------------------------------------------
`ifdef PWM_DEADTIME_EN
   localparam int          DTW    = $clog2(DT + 1);
   localparam logic [DTW-1:0] DT_SAT = DTW'(DT);

   // raw_prev_q is the raw level of the previous running clock; same_q counts
   // how many consecutive previous running clocks had that level (saturating at
   // DT). An output may be high only when the current raw matches the previous
   // level and that level has already been held for DT clocks.
   logic           raw_prev_q, raw_prev_d;
   logic [DTW-1:0] same_q, same_d;

   always_comb begin
      raw_prev_d = 1'b0;
      same_d     = '0;
      pwm_out_d  = 1'b0;
      pwm_outn_d = 1'b0;
      if (run_ok) begin
         raw_prev_d = raw;
         if (raw == raw_prev_q) begin
            same_d = (same_q == DT_SAT) ? same_q : same_q + 1'b1;
         end else begin
            same_d = DTW'(1);
         end
         pwm_out_d  =  raw &&  raw_prev_q && (same_q == DT_SAT);
         pwm_outn_d = !raw && !raw_prev_q && (same_q == DT_SAT);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         raw_prev_q <= 1'b0;
         same_q     <= '0;
      end else begin
         raw_prev_q <= raw_prev_d;
         same_q     <= same_d;
      end
   end
`else
   always_comb begin
      pwm_out_d  = run_ok &&  raw;
      pwm_outn_d = run_ok && !raw;
   end
`endif

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         pre_cnt_q    <= '0;
         presc_q      <= '0;
         cnt_q        <= '0;
         duty_q       <= '0;
         pwm_out      <= 1'b0;
         pwm_outn     <= 1'b0;
         period_start <= 1'b0;
      end else begin
         state_q      <= state_d;
         pre_cnt_q    <= pre_cnt_d;
         presc_q      <= presc_d;
         cnt_q        <= cnt_d;
         duty_q       <= duty_d;
         pwm_out      <= pwm_out_d;
         pwm_outn     <= pwm_outn_d;
         period_start <= period_start_d;
      end
   end

endmodule

// File: tb/tb_dds_pwm_dac.sv
// -----------------------------------------------------------------------------
// tb_dds_pwm_dac
//
// Randomized bench for dds_pwm_dac. The reference model tracks the position in
// the PWM period as a plain clock count t since the period began; the carrier
// value is t/(prescale+1) and the period ends after (prescale+1)*1024 clocks.
// Inputs change on the falling edge; outputs are compared on the falling edge
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_dds_pwm_dac;

   localparam int DW = 10;
   localparam int DT = 4;
   localparam int NPER = 1 << DW;

   logic          clk = 1'b0;
   logic          rstn;
   logic          pwm_ena;
   logic [DW-1:0] din;
   logic [7:0]    prescale;
   logic          pwm_out;
   logic          pwm_outn;
   logic          period_start;
   logic [DW-1:0] duty_q;

   dds_pwm_dac #(.DW(DW), .DT(DT)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .pwm_ena      (pwm_ena),
      .din          (din),
      .prescale     (prescale),
      .pwm_out      (pwm_out),
      .pwm_outn     (pwm_outn),
      .period_start (period_start),
      .duty_q       (duty_q)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   int m_mode;          // 0 stopped, 1 about to start, 2 modulating
   int m_t;             // clocks elapsed in the current period
   int m_duty;
   int m_presc;
   bit e_out, e_outn, e_ps;
   bit hist[$];         // raw levels since modulation began (dead-time build)

   task automatic model_edge();
      int  c;
      bit  raw;
      bit  held;
      if (!rstn) begin
         m_mode = 0; m_t = 0; m_duty = 0; m_presc = 0;
         e_out = 0; e_outn = 0; e_ps = 0;
         hist.delete();
         return;
      end
      e_out = 0; e_outn = 0; e_ps = 0;
      case (m_mode)
         0: begin
            m_t = 0;
            hist.delete();
            if (pwm_ena) m_mode = 1;
         end
         1: begin
            m_t = 0;
            hist.delete();
            if (!pwm_ena) m_mode = 0;
            else begin
               m_duty = int'(din); m_presc = int'(prescale);
               e_ps = 1; m_mode = 2;
            end
         end
         default: begin
            if (!pwm_ena) begin
               m_mode = 0; m_t = 0;
               hist.delete();
            end else begin
               c   = m_t / (m_presc + 1);
               raw = (c < m_duty);
`ifdef PWM_DEADTIME_EN
               held = (hist.size() >= DT);
               for (int k = 1; k <= DT; k++)
                  if (held && hist[hist.size() - k] != raw) held = 0;
               e_out  = raw && held;
               e_outn = !raw && held;
               hist.push_back(raw);
               if (hist.size() > DT) void'(hist.pop_front());
`else
               held   = 1;
               e_out  = raw && held;
               e_outn = !raw && held;
`endif
               m_t++;
               if (m_t == (m_presc + 1) * NPER) begin
                  m_t = 0;
                  m_duty = int'(din); m_presc = int'(prescale);
                  e_ps = 1;
               end
            end
         end
      endcase
   endtask

   // One clock: model the coming edge, let it happen, compare mid-low-phase.
   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check("pwm_out",      32'(pwm_out),      32'(e_out));
      check("pwm_outn",     32'(pwm_outn),     32'(e_outn));
      check("period_start", 32'(period_start), 32'(e_ps));
      check("duty_q",       32'(duty_q),       32'(m_duty));
   endtask

   function automatic logic [DW-1:0] pick_din();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return {DW{1'b1}};
         2: return DW'(512);
         3: return DW'(1);
         4: return DW'(NPER - 2);
         default: return DW'($urandom_range(0, NPER - 1));
      endcase
   endfunction

   function automatic logic [7:0] pick_presc();
      case ($urandom_range(0, 3))
         0, 1: return 8'd0;
         2: return 8'd1;
         default: return 8'd3;
      endcase
   endfunction

   int  highs;
   int  waited;
   bit  seen;

   initial begin
      rstn = 1'b0; pwm_ena = 1'b1; din = DW'(700); prescale = 8'd2;
      @(negedge clk);
      // Reset wins even with enable asserted.
      step();
      step();

      // Steady 50 % duty at full carrier rate.
      rstn = 1'b1; din = DW'(512); prescale = 8'd0;
      seen = 0; waited = 0;
      while (!seen && waited < 8) begin
         step();
         waited++;
         seen = period_start;
      end
      check("first_period_start", 32'(seen), 32'd1);
      check("first_period_latency", 32'(waited), 32'd2);

      highs = 0;
      for (int i = 0; i < NPER; i++) begin
         step();
         highs += int'(pwm_out);
         if (i < NPER - 1) check("no_early_strobe", 32'(period_start), 32'd0);
      end
`ifdef PWM_DEADTIME_EN
      check("high_clks_512", 32'(highs), 32'd508);
`else
      check("high_clks_512", 32'(highs), 32'd512);
`endif
      check("period_1024", 32'(period_start), 32'd1);

      // Randomized segments: duty/prescale changes at arbitrary points,
      // enable drops/re-enables and occasional resets.
      for (int seg = 0; seg < 14; seg++) begin
         int ncyc;
         din      = pick_din();
         prescale = pick_presc();
         pwm_ena  = 1'b1;
         rstn     = 1'b1;
         ncyc     = 2500 + int'($urandom_range(0, 1500));
         for (int i = 0; i < ncyc; i++) begin
            if ($urandom_range(0, 299) == 0) din = pick_din();
            if ($urandom_range(0, 699) == 0) prescale = pick_presc();
            if ($urandom_range(0, 899) == 0) pwm_ena = ~pwm_ena;
            if ($urandom_range(0, 1499) == 0) begin
               // one-clock enable drop, possibly landing on a start cycle
               pwm_ena = 1'b0;
               step();
               pwm_ena = 1'b1;
            end
            rstn = ($urandom_range(0, 4999) == 0) ? 1'b0 : 1'b1;
            step();
         end
      end

      // Hold in reset mid-run: everything returns to zero.
      rstn = 1'b0;
      step();
      check("rst_pwm_out",  32'(pwm_out),  32'd0);
      check("rst_pwm_outn", 32'(pwm_outn), 32'd0);
      check("rst_duty_q",   32'(duty_q),   32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
